// File: rtl/count_event_capture_pkg.sv
// count_event_pkg: event type codes and record width for count_event_capture.
// Defining COUNT_EVENT_TS_EN appends a timestamp field to each record.
package count_event_pkg;
    localparam logic [1:0] EV_CLEAR = 2'b00;
    localparam logic [1:0] EV_MATCH = 2'b01;
    localparam logic [1:0] EV_WRAP  = 2'b10;
    localparam logic [1:0] EV_BOTH  = 2'b11;
`ifdef COUNT_EVENT_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    function automatic int rec_w(input int cnt_w, input int ts_w);
        return 2 + cnt_w + (TS_EN ? ts_w : 0);
    endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: pointer-based FIFO with a registered head-of-queue output.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr, rd, nrd;
    logic push_ok, pop_ok;
    assign full    = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
    assign empty   = wr == rd;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign nrd     = rd + PW'(pop_ok);
    always_ff @(posedge clk)
        if (push_ok) mem[wr[AW-1:0]] <= din;
    // The next head is forwarded from din when it is the slot written this edge.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr   <= '0;
            rd   <= '0;
            dout <= '0;
        end else begin
            wr   <= wr + PW'(push_ok);
            rd   <= nrd;
            dout <= (push_ok && nrd == wr) ? din : mem[nrd[AW-1:0]];
        end
endmodule

// File: rtl/count_event_capture.sv
// count_event_capture: logs wrap/match/clear events of a counter into a FIFO.
// Defining COUNT_EVENT_TS_EN appends a free-running timestamp to each record.
module count_event_capture
    import count_event_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CNT_W-1:0]                  count,
    input  logic                              cmp_en,
    input  logic [CNT_W-1:0]                  cmp_val,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [rec_w(CNT_W, TS_W)-1:0]     out_data,
    output logic                              overflow,
    output logic [7:0]                        drop_cnt,
    input  logic                              clr_ovf
);
    localparam int REC_W = rec_w(CNT_W, TS_W);
    localparam logic [CNT_W-1:0] ONES = '1;
    logic [CNT_W-1:0] prev_cnt;
    logic wrap, match, clear, ev, pop, full, empty, drop;
    logic [1:0] ev_type;
    logic [REC_W-1:0] rec;
    always_comb begin
        wrap    = prev_cnt == ONES && count == '0;
        match   = count != prev_cnt && cmp_en && count == cmp_val;
        clear   = count == '0 && prev_cnt != '0 && prev_cnt != ONES;
        ev      = wrap || match || clear;
        ev_type = wrap ? (match ? EV_BOTH : EV_WRAP) : (match ? EV_MATCH : EV_CLEAR);
    end
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = ev && full && !pop;
`ifdef COUNT_EVENT_TS_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clk or negedge reset)
        if (!reset) ts <= '0;
        else ts <= ts + 1'b1;
    assign rec = {ev_type, count, ts};
`else
    assign rec = {ev_type, count};
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            prev_cnt <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            prev_cnt <= count;
            overflow <= drop || (overflow && !clr_ovf);
            drop_cnt <= clr_ovf ? {7'd0, drop} : drop_cnt + 8'(drop && drop_cnt != 8'hff);
        end
    event_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev),
        .din   (rec),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .dout  (out_data)
    );
endmodule

// File: tb/tb_count_event_capture.sv
// tb_count_event_capture: directed table, corner sequences and randomized
// traffic against a queue-based reference model of the event logger.
module tb_count_event_capture;
    import count_event_pkg::*;
    localparam int RW = rec_w(8, 16);

    logic clk = 0, reset = 0;
    logic [7:0] count = 0, cmp_val = 0;
    logic cmp_en = 0, out_ready = 0, clr_ovf = 0;
    logic out_valid, overflow;
    logic [RW-1:0] out_data;
    logic [7:0] drop_cnt;
    logic [9:0] got;
    assign got = out_data[RW-1 -: 10];

    count_event_capture dut (
        .clk(clk), .reset(reset), .count(count), .cmp_en(cmp_en), .cmp_val(cmp_val),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [9:0] m_q[$];
    logic [7:0] m_prev = 0;
    logic m_ovf = 0;
    int m_drop = 0;

    typedef struct {
        logic [7:0] c;
        logic       en;
        logic [7:0] v;
        logic       rdy;
        logic       exp_valid;
        logic [9:0] exp_rec;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", int'(out_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("out_data", int'(got), int'(m_q[0]));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic model_edge(input logic [7:0] c, input logic en, input logic [7:0] v,
                              input logic rdy, input logic clr);
        bit w, m, cl, pop;
        int sz;
        w   = m_prev == 8'hff && c == 0;
        m   = c != m_prev && en && c == v;
        cl  = c == 0 && m_prev != 0 && m_prev != 8'hff;
        sz  = m_q.size();
        pop = sz > 0 && rdy;
        if (pop) void'(m_q.pop_front());
        if (clr) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        if (w || m || cl) begin
            if (sz < 8 || pop) m_q.push_back({w, m, c});
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_prev = c;
    endtask

    task automatic step(input logic [7:0] c, input logic en, input logic [7:0] v,
                        input logic rdy, input logic clr);
        count = c; cmp_en = en; cmp_val = v; out_ready = rdy; clr_ovf = clr;
        model_edge(c, en, v, rdy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        m_q.delete();
        m_prev = 0; m_ovf = 0; m_drop = 0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    function automatic void add(input logic [7:0] c, input logic en, input logic [7:0] v,
                                input logic rdy, input logic ev, input logic [9:0] er);
        vecs.push_back('{c: c, en: en, v: v, rdy: rdy, exp_valid: ev, exp_rec: er});
    endfunction

    initial begin
        for (int i = 0; i < 5; i++) add(8'd0, 0, 8'd0, 1, 0, 10'h0);
        for (int k = 0; k <= 12; k++) add(8'(k), 1, 8'd10, 1, k == 10, 10'h10A);
        for (int k = 250; k <= 255; k++) add(8'(k), 1, 8'd0, 1, 0, 10'h0);
        add(8'd0, 1, 8'd0, 1, 1, 10'h300);
        add(8'd1, 1, 8'd0, 1, 0, 10'h0);
        add(8'd40, 0, 8'd0, 1, 0, 10'h0);
        add(8'd0, 0, 8'd0, 1, 1, 10'h000);
        add(8'd0, 0, 8'd0, 1, 0, 10'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", int'(out_valid), 0);
        chk("init_data", int'(got), 0);
        chk("init_ovf", int'(overflow), 0);
        chk("init_drop", int'(drop_cnt), 0);
        reset = 1;

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].en, vecs[i].v, vecs[i].rdy, 0);
            chk("tbl_valid", int'(out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk("tbl_rec", int'(got), int'(vecs[i].exp_rec));
        end

        for (int k = 1; k <= 11; k++) step(8'(k), 1, 8'(k), 0, 0);
        chk("fill_ovf", int'(overflow), 1);
        chk("fill_drop", int'(drop_cnt), 3);
        chk("fill_head", int'(got), 10'h101);
        out_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_rec", int'(got), int'({2'b01, 8'(k)}));
            step(8'd11, 1, 8'd0, 1, 0);
        end
        chk("drain_empty", int'(out_valid), 0);

        for (int k = 20; k <= 27; k++) step(8'(k), 1, 8'(k), 0, 0);
        step(8'd28, 1, 8'd28, 1, 0);
        chk("poppush_drop", int'(drop_cnt), 3);
        chk("poppush_valid", int'(out_valid), 1);
        step(8'd28, 1, 8'd0, 0, 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_drop", int'(drop_cnt), 0);
        step(8'd29, 1, 8'd29, 0, 1);
        chk("clr_drop_ovf", int'(overflow), 1);
        chk("clr_drop_cnt", int'(drop_cnt), 1);
        do_reset();
        chk("midrst_valid", int'(out_valid), 0);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] c, v;
            r = $urandom_range(0, 9);
            v = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255));
            c = r < 6 ? count + 8'd1 : r == 6 ? count : r == 7 ? 8'd0 : r == 8 ? 8'($urandom) : v;
            step(c, 1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
